// File: rtl/cdc_app_pkg.sv
// Shared types and constants for the usb_cdc application-side byte path.
package cdc_app_pkg;

  localparam int unsigned BYTE_W               = 8;
  localparam int unsigned CNT_W                = 8;
  localparam int unsigned DEFAULT_MAX_BURST    = 64;
  localparam int unsigned DEFAULT_IDLE_TIMEOUT = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Saturating increment for the burst and idle counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cdc_in_arbiter_rr_pick.sv
// Circular priority encoder: first asserted request after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic             valid_o
);

  // Walk distances from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      for (int j = 0; j < int'(N_REQ); j++) begin
        if (req_i[j] && (j == ((int'(ptr_i) + i) % int'(N_REQ)))) begin
          pick_o    = '0;
          pick_o[j] = 1'b1;
          valid_o   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdc_in_arbiter.sv
// Round-robin, message-granular arbiter in front of the usb_cdc IN byte stream.
module cdc_in_arbiter
  import cdc_app_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned MAX_BURST    = DEFAULT_MAX_BURST,
  parameter int unsigned IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [BYTE_W*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [BYTE_W-1:0]       in_data_o,
  output logic                    in_valid_o,
  input  logic                    in_ready_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    busy_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_n_req
    $error("cdc_in_arbiter: N_REQ must be in 2..8");
  end
  if ((MAX_BURST < 1) || (MAX_BURST > 255)) begin : g_bad_max_burst
    $error("cdc_in_arbiter: MAX_BURST must be in 1..255");
  end
  if ((IDLE_TIMEOUT < 1) || (IDLE_TIMEOUT > 255)) begin : g_bad_idle_timeout
    $error("cdc_in_arbiter: IDLE_TIMEOUT must be in 1..255");
  end

  arb_state_e         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [CNT_W-1:0]   idle_q, idle_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               load_ok_c;
  logic               xfer_c;
  logic               rel_c;
  logic [N_REQ-1:0]   pick_c;
  logic               pick_vld_c;
  logic [BYTE_W-1:0]  g_data_c;
  logic               g_valid_c;
  logic               g_last_c;
  logic [PTR_W-1:0]   g_idx_c;
  logic [CNT_W-1:0]   burst_inc_c;
  logic [CNT_W-1:0]   idle_inc_c;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .pick_o  (pick_c),
    .valid_o (pick_vld_c)
  );

  // Select the current grantee's byte, flags and index from the one-hot grant.
  always_comb begin
    g_data_c  = '0;
    g_valid_c = 1'b0;
    g_last_c  = 1'b0;
    g_idx_c   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (grant_q[k]) begin
        g_data_c  = req_data_i[k*BYTE_W +: BYTE_W];
        g_valid_c = req_valid_i[k];
        g_last_c  = req_last_i[k];
        g_idx_c   = PTR_W'(k);
      end
    end
  end

  assign load_ok_c   = !valid_q || in_ready_i;
  assign req_ready_o = grant_q & {N_REQ{load_ok_c}};
  assign xfer_c      = g_valid_c && load_ok_c;
  assign burst_inc_c = sat_inc(burst_q);
  assign idle_inc_c  = sat_inc(idle_q);

  // Grant FSM: a transfer always takes precedence over the idle timeout.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    rel_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_c) begin
          grant_d = pick_c;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer_c) begin
          burst_d = burst_inc_c;
          idle_d  = '0;
          rel_c   = g_last_c || (burst_inc_c == CNT_W'(MAX_BURST));
        end else if (!g_valid_c) begin
          idle_d = idle_inc_c;
          rel_c  = (idle_inc_c == CNT_W'(IDLE_TIMEOUT));
        end
        if (rel_c) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = g_idx_c;
          burst_d = '0;
          idle_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // One-byte output register; drains regardless of the grant state.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (xfer_c) begin
      data_d  = g_data_c;
      valid_d = 1'b1;
    end else if (in_ready_i) begin
      valid_d = 1'b0;
    end
    busy_d = (state_d == ST_GRANT) || valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
      burst_q <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign in_data_o  = data_q;
  assign in_valid_o = valid_q;
  assign grant_o    = grant_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Directed bench for cdc_in_arbiter (N_REQ=2, MAX_BURST=4, IDLE_TIMEOUT=16).
module tb_cdc_in_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned MB  = 4;
  localparam int unsigned ITO = 16;

  logic           clk;
  logic           rstn_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_o;
  logic [7:0]     in_data_o;
  logic           in_valid_o;
  logic           in_ready_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  cdc_in_arbiter #(
    .N_REQ        (N),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (ITO)
  ) u_dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source queues hold {last, data}; the sink log records bytes taken by usb_cdc.
  logic [8:0] srcq [N][$];
  logic [7:0] out_log [$];
  logic [7:0] exp_log [$];
  logic [N-1:0] src_en;
  int         rdy_mode;
  int         cyc;
  logic       stall_q;
  logic [7:0] stall_data;
  int         n_vec;
  int         n_miss;
  int         n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_src(input int k, input logic [7:0] first, input int cnt, input bit with_last);
    for (int i = 0; i < cnt; i++)
      srcq[k].push_back({with_last && (i == cnt - 1), first + 8'(i)});
  endtask

  task automatic push_exp(input logic [7:0] first, input int cnt);
    for (int i = 0; i < cnt; i++) exp_log.push_back(first + 8'(i));
  endtask

  // Drive one cycle at the falling edge, sample 1 ns later, advance to next falling edge.
  task automatic cycle();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (src_en[k] && (srcq[k].size() > 0)) begin
        v[k]         = 1'b1;
        d[k*8 +: 8]  = srcq[k][0][7:0];
        l[k]         = srcq[k][0][8];
      end
    end
    req_valid_i = v;
    req_last_i  = l;
    req_data_i  = d;
    case (rdy_mode)
      1:       in_ready_i = (cyc % 2 == 0);
      2:       in_ready_i = 1'b0;
      default: in_ready_i = 1'b1;
    endcase
    #1;
    if (stall_q && rstn_i) begin
      chk("stall_valid", 32'(in_valid_o), 32'(1));
      chk("stall_data", 32'(in_data_o), 32'(stall_data));
    end
    stall_q    = in_valid_o && !in_ready_i && rstn_i;
    stall_data = in_data_o;
    for (int k = 0; k < int'(N); k++)
      if (req_valid_i[k] && req_ready_o[k]) void'(srcq[k].pop_front());
    if (in_valid_o && in_ready_i && rstn_i) out_log.push_back(in_data_o);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic run_until_empty(input int limit);
    int c;
    c = 0;
    while (((srcq[0].size() > 0 && src_en[0]) || (srcq[1].size() > 0 && src_en[1])) && c < limit) begin
      cycle();
      c++;
    end
    chk("run_bound", 32'(c < limit), 32'(1));
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(out_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(out_log[i]), 32'(exp_log[i]));
  endtask

  task automatic do_reset();
    rstn_i      = 1'b0;
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    in_ready_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstn_i = 1'b1;
    for (int k = 0; k < int'(N); k++) srcq[k].delete();
    out_log.delete();
    exp_log.delete();
    src_en   = '1;
    rdy_mode = 0;
    stall_q  = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    cyc    = 0;

    // Reset values.
    do_reset();
    chk("rst_grant", 32'(grant_o), 32'(0));
    chk("rst_valid", 32'(in_valid_o), 32'(0));
    chk("rst_data", 32'(in_data_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));

    // Single requester, 7-byte message; split by the 4-byte burst limit.
    load_src(0, 8'h01, 7, 1'b1);
    n = 0;
    while (srcq[0].size() > 0 && n < 100) begin
      cycle();
      n++;
    end
    chk("single_cycles", 32'(n), 32'(9));
    chk("single_grant_rel", 32'(grant_o), 32'(0));
    chk("single_last_out", 32'(in_data_o), 32'(8'h07));
    chk("single_busy", 32'(busy_o), 32'(1));
    drain();
    chk("single_idle_busy", 32'(busy_o), 32'(0));
    push_exp(8'h01, 7);
    check_log("single");

    // Contention with 3-byte messages: whole messages alternate.
    do_reset();
    load_src(0, 8'hA0, 3, 1'b1);
    load_src(0, 8'hA0, 3, 1'b1);
    load_src(1, 8'hB0, 3, 1'b1);
    load_src(1, 8'hB0, 3, 1'b1);
    run_until_empty(100);
    drain();
    push_exp(8'hA0, 3); push_exp(8'hB0, 3);
    push_exp(8'hA0, 3); push_exp(8'hB0, 3);
    check_log("contend");

    // Backpressure: in_ready toggles during a 16-byte message.
    do_reset();
    rdy_mode = 1;
    load_src(0, 8'h10, 16, 1'b1);
    run_until_empty(200);
    drain();
    push_exp(8'h10, 16);
    check_log("bp");

    // Burst limit: requester 0 is cut after 4 bytes, requester 1 gets a turn.
    do_reset();
    load_src(0, 8'h40, 10, 1'b1);
    load_src(1, 8'h70, 2, 1'b1);
    run_until_empty(200);
    drain();
    push_exp(8'h40, 4); push_exp(8'h70, 2);
    push_exp(8'h44, 4); push_exp(8'h48, 2);
    check_log("burst");

    // Idle timeout: grantee stalls after 2 bytes, then resumes on a later grant.
    do_reset();
    load_src(0, 8'h50, 3, 1'b1);
    load_src(1, 8'h60, 1, 1'b1);
    n = 0;
    while (srcq[0].size() > 1 && n < 50) begin
      cycle();
      n++;
    end
    src_en[0] = 1'b0;
    chk("to_grant_held", 32'(grant_o), 32'(2'b01));
    n = 0;
    while (grant_o == 2'b01 && n < 40) begin
      cycle();
      n++;
    end
    chk("to_hold_cycles", 32'(n), 32'(ITO));
    chk("to_grant_rel", 32'(grant_o), 32'(0));
    cycle();
    chk("to_regrant", 32'(grant_o), 32'(2'b10));
    drain();
    src_en[0] = 1'b1;
    run_until_empty(100);
    drain();
    exp_log.push_back(8'h50); exp_log.push_back(8'h51);
    exp_log.push_back(8'h60); exp_log.push_back(8'h52);
    check_log("timeout");

    // Reset with a pending byte and in_ready low.
    do_reset();
    rdy_mode = 2;
    load_src(0, 8'h33, 2, 1'b1);
    load_src(1, 8'h77, 1, 1'b1);
    cycle();
    cycle();
    chk("prerst_valid", 32'(in_valid_o), 32'(1));
    chk("prerst_data", 32'(in_data_o), 32'(8'h33));
    rstn_i = 1'b0;
    cycle();
    rstn_i = 1'b1;
    chk("mrst_valid", 32'(in_valid_o), 32'(0));
    chk("mrst_grant", 32'(grant_o), 32'(0));
    chk("mrst_busy", 32'(busy_o), 32'(0));
    rdy_mode = 0;
    cycle();
    chk("mrst_first_grant", 32'(grant_o), 32'(2'b01));
    run_until_empty(100);
    drain();
    exp_log.push_back(8'h34); exp_log.push_back(8'h77);
    check_log("mrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cdc_in_arbiter.md
# cdc_in_arbiter

Round-robin arbiter sharing the `usb_cdc` IN byte stream (`in_data`/`in_valid`/`in_ready`) between several SoC-side byte producers, e.g. the echo/increment loopback path and a status reporter. A grant is held for a whole message, so requester bytes never interleave inside a message. A grant is also released after a byte-count limit or an idle timeout, so no requester can starve the others. The block sits in the SoC app-clock domain, directly in front of the `usb_cdc` IN interface.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `MAX_BURST`, 64: max bytes per grant before forced release (1..255).
- `IDLE_TIMEOUT`, 16: cycles the grantee may hold `valid` low before forced release (1..255).
- `clk_i`  in  1  app clock; all logic on its rising edge.
- `rstn_i`  in  1  reset; **synchronous, active-low**.
- `req_data_i`  in  8*N_REQ  byte from requester k at bits [8k+7:8k].
- `req_valid_i`  in  N_REQ  byte valid, per requester.
- `req_last_i`  in  N_REQ  byte is the last of a message; qualified by valid.
- `req_ready_o`  out  N_REQ  byte accepted this cycle (combinational).
- `in_data_o`  out  8  byte to `usb_cdc` IN stream (registered).
- `in_valid_o`  out  1  byte valid (registered).
- `in_ready_i`  in  1  `usb_cdc` accepts the byte.
- `grant_o`  out  N_REQ  one-hot current grant (registered); all zero when idle.
- `busy_o`  out  1  grant held, or output register full.

## Operation
- Output register: one byte, `in_data_o`/`in_valid_o`. It may load when `load_ok = !in_valid_o || in_ready_i`.
- `req_ready_o[k] = grant_o[k] && load_ok`. A byte transfers when `req_valid_i[k] && req_ready_o[k]`.
- On a transfer, the byte loads into the output register and `in_valid_o` is set. `in_valid_o` clears on `in_ready_i` when no load happens in the same cycle.
- FSM states:
  - `IDLE`: `grant_o` is 0. If any `req_valid_i` bit is set, pick the first asserted index searching circularly from `ptr+1`. Set `grant_o` to that index and go to `GRANT`; the grant takes effect next cycle.
  - `GRANT`: on each transferred byte, `burst_cnt++` and `idle_cnt` clears. Each cycle the grantee has valid low, `idle_cnt++`. Release back to `IDLE` on any of:
    - transferred byte with `last`;
    - transferred byte that makes `burst_cnt == MAX_BURST`;
    - `idle_cnt` reaches `IDLE_TIMEOUT`.
  - On release: `ptr` = released index, counters clear, `grant_o` goes to 0 next cycle.
- The output register drains independently of FSM state. A byte pending at release is still delivered.
- A requester that drops `valid` mid-message without `last` keeps the grant until the timeout. After the forced release, its message continues on its next grant.
- `req_data_i`/`req_last_i` of non-granted requesters are ignored.
- Counter widths are 8 bits and saturating. Parameter checks are elaboration-time assertions.

## Timing
- Reset values: `grant_o`=0, `in_valid_o`=0, `in_data_o`=8'h00, `busy_o`=0, `ptr`=N_REQ-1 (so requester 0 wins first), counters 0, state `IDLE`.
- Reset mid-operation drops any pending output byte and grant at the next edge. No partial byte appears after reset.
- Latency: request to grant is 1 cycle. Transfer to `in_valid_o` is 1 cycle. Minimum re-arbitration gap between grants is 1 idle cycle.
- Throughput: 1 byte/cycle while `in_ready_i` is held high.
- Simultaneous events:
  - Last byte transferring while `in_ready_i` drains the previous byte: both happen.
  - `last` on the byte that also reaches `MAX_BURST`: a single release.
  - Timeout in the same cycle as `valid` rising: the transfer wins and `idle_cnt` clears.
- `in_valid_o` never drops without `in_ready_i`. `in_data_o` is stable while `in_valid_o && !in_ready_i`.

## Structure
- Shared package `cdc_app_pkg`: FSM state enum (`ST_IDLE`, `ST_GRANT`), byte width constant, default `MAX_BURST`/`IDLE_TIMEOUT`.
- One sub-module, `rr_pick`: combinational circular priority encoder, inputs request vector and `ptr`, outputs one-hot pick and valid. Everything else stays in the top module.

## Test plan
- Single requester, `in_ready_i`=1: requester 0 sends 8'h01..8'h07 with `last` on 8'h07 -> the IN stream carries 01..07 in order, `grant_o` returns to 0 one cycle after 07 is accepted.
- Contention: both requesters continuously valid, 3-byte messages (A0-A2 from requester 0, B0-B2 from requester 1) -> output order A0 A1 A2 B0 B1 B2 A0…, never interleaved within a message.
- Backpressure: `in_ready_i` toggles 1-0-1-0 during a 16-byte message -> all 16 bytes delivered exactly once, `in_data_o` stable while stalled.
- Burst limit: `MAX_BURST`=4, requester 0 sends a 10-byte message while requester 1 is valid -> grant switches to requester 1 after byte 4, and requester 0 resumes at byte 5 on its next grant.
- Timeout: `IDLE_TIMEOUT`=16, the grantee stalls valid after 2 bytes -> release after 16 cycles, and requester 1 is granted on the next cycle.
- Reset: assert `rstn_i`=0 for one cycle with a byte pending and `in_ready_i`=0 -> next cycle `in_valid_o`=0, `grant_o`=0, and the first grant afterwards goes to requester 0.
